// File: rtl/ahb_pixel_pkg.sv
// Shared encodings for the AHB-Lite pixel FIFO: register map, control/status
// bit positions, AHB transfer encodings and the bus response state type.
package ahb_pixel_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Register word indices as seen on HADDR[7:2].
  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_DATA   = 6'h02;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_CLR        = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int CTRL_THRESH_LSB = 8;

  localparam int STAT_LEVEL_W = 9;
  localparam int STAT_EMPTY   = 16;
  localparam int STAT_FULL    = 17;
  localparam int STAT_OVF     = 18;
  localparam int STAT_UNF     = 19;

  typedef enum logic [1:0] {
    RESP_OKAY,
    RESP_ERR1,
    RESP_ERR2
  } resp_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port, synchronous flush and an
// occupancy count; a pop frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~clear & ~empty;
  assign push_ok = push & ~clear & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; its contents are only observable
  // through level/rd_ptr, which are reset, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ahb_pixel_fifo.sv
// AHB-Lite slave that packs camera pixel bytes into 32-bit words, buffers
// them in a FIFO and exposes CTRL/STATUS/DATA registers plus a level IRQ.
module ahb_pixel_fifo
  import ahb_pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        SYSCLK,
  input  logic        NSYSRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [7:0]  PIX_DATA,
  input  logic        PIX_VALID,
  output logic        FIFO_IRQ
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  resp_state_e resp_st;
  logic        dp_valid;
  logic        dp_write;
  logic [5:0]  dp_idx;

  logic        ctrl_en;
  logic        irq_en;
  logic [7:0]  thresh;
  logic        ovf;
  logic        unf;

  logic [1:0]  pix_cnt;
  logic [23:0] pix_word;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_clear;
  logic               fifo_full;
  logic               fifo_empty;
  logic [31:0]        fifo_rdata;
  logic [LEVEL_W-1:0] fifo_level;

  logic        addr_acc;
  logic        addr_err;
  logic [5:0]  addr_idx;
  logic        wr_ctrl;
  logic        wr_status;
  logic        rd_data;
  logic        pix_take;
  logic        ovf_set;
  logic        unf_set;
  logic [31:0] ctrl_word;
  logic [31:0] status_word;
  logic        unused_bits;

  assign addr_idx = HADDR[7:2];
  assign addr_acc = HSEL & HREADYIN &
                    ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign addr_err = (addr_idx > REG_DATA) | (HSIZE != HSIZE_WORD) |
                    (HWRITE & (addr_idx == REG_DATA));

  assign unused_bits = ^{HADDR[31:8], HADDR[1:0], HWDATA};

  // Errored transfers never open a data phase, so they cannot touch any register.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      resp_st   <= RESP_OKAY;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
    end else begin
      dp_valid <= 1'b0;
      case (resp_st)
        RESP_ERR1: begin
          resp_st   <= RESP_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (addr_acc && addr_err) begin
            resp_st   <= RESP_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else begin
            resp_st   <= RESP_OKAY;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            if (addr_acc) begin
              dp_valid <= 1'b1;
              dp_write <= HWRITE;
              dp_idx   <= addr_idx;
            end
          end
        end
      endcase
    end
  end

  assign wr_ctrl    = dp_valid & dp_write & (dp_idx == REG_CTRL);
  assign wr_status  = dp_valid & dp_write & (dp_idx == REG_STATUS);
  assign rd_data    = dp_valid & ~dp_write & (dp_idx == REG_DATA);
  assign fifo_clear = wr_ctrl & HWDATA[CTRL_CLR];
  assign fifo_pop   = rd_data & ~fifo_empty;
  assign unf_set    = rd_data & fifo_empty;

  assign pix_take  = ctrl_en & PIX_VALID;
  assign fifo_push = pix_take & (pix_cnt == 2'd3);
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop & ~fifo_clear;

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      ctrl_en <= 1'b0;
      irq_en  <= 1'b0;
      thresh  <= '0;
    end else if (wr_ctrl) begin
      ctrl_en <= HWDATA[CTRL_EN];
      irq_en  <= HWDATA[CTRL_IRQ_EN];
      thresh  <= HWDATA[CTRL_THRESH_LSB +: 8];
    end
  end

  // A flush or a disabled packer throws away any bytes gathered so far.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      pix_cnt  <= '0;
      pix_word <= '0;
    end else if (fifo_clear || !ctrl_en) begin
      pix_cnt <= '0;
    end else if (pix_take) begin
      pix_cnt <= pix_cnt + 1'b1;
      case (pix_cnt)
        2'd0:    pix_word[7:0]   <= PIX_DATA;
        2'd1:    pix_word[15:8]  <= PIX_DATA;
        2'd2:    pix_word[23:16] <= PIX_DATA;
        default: pix_word        <= pix_word;
      endcase
    end
  end

  // A fresh error event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (ovf & ~(wr_status & HWDATA[STAT_OVF])) | ovf_set;
      unf <= (unf & ~(wr_status & HWDATA[STAT_UNF])) | unf_set;
    end
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) FIFO_IRQ <= 1'b0;
    else FIFO_IRQ <= irq_en & (thresh != 8'd0) &
                     (status_word[STAT_LEVEL_W-1:0] >= {1'b0, thresh});
  end

  assign ctrl_word = {16'h0, thresh, 5'h0, irq_en, 1'b0, ctrl_en};

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    status_word                = '0;
    status_word[LEVEL_W-1:0]   = fifo_level;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_OVF]      = ovf;
    status_word[STAT_UNF]      = unf;
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_idx)
        REG_CTRL:   HRDATA = ctrl_word;
        REG_STATUS: HRDATA = status_word;
        REG_DATA:   HRDATA = fifo_empty ? 32'h0 : fifo_rdata;
        default:    HRDATA = '0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (SYSCLK),
    .rst_n (NSYSRESET),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({PIX_DATA, pix_word}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule
